// File: rtl/prog_loader.sv
// Boot-time program loader sitting in front of the CPU core.
// It takes a header word and N program words from a valid/ready stream,
// writes them to imem addresses 0..N-1, and then releases the core from reset.
// It counts the core's run cycles until done, or stops at a timeout.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | core held in reset, waiting for start
// HDR    | waiting for the header word (length - 1, bit IW-1 must be 0)
// LOAD   | streaming program words into imem
// SETTLE | one cycle for the final imem write to land before the core runs
// RUN    | core running, counting cycles until done or timeout
// DONE   | core finished; cycle_cnt frozen, start returns to IDLE
// ERR    | bad header or timeout; cycle_cnt frozen, start returns to IDLE
module prog_loader #(
    parameter int IW         = 9,
    parameter int AW         = 8,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_valid,
    input  logic [IW-1:0] s_data,
    output logic          s_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [IW-1:0] im_data,
    output logic          cpu_reset,
    input  logic          cpu_done,
    output logic [CW-1:0] cycle_cnt,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // A RUN cycle that starts with the count at this value is the last one before timeout.
    localparam logic [CW-1:0] RUN_TC = CW'(MAX_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] len_cnt;     // words still to come after the current one
    logic [AW-1:0] addr_cnt;
    logic          xfer;
    logic          hdr_bad;
    logic          last_word;
    logic          run_tc;

    assign xfer      = s_valid && s_ready;
    assign hdr_bad   = s_data[IW-1];
    assign last_word = (len_cnt == '0);
    assign run_tc    = (cycle_cnt == RUN_TC);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; done takes priority over the timeout on the same edge
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_HDR;
            S_HDR:    if (xfer) state_nx = hdr_bad ? S_ERR : S_LOAD;
            S_LOAD:   if (xfer && last_word) state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_RUN;
            S_RUN: begin
                if (cpu_done) begin
                    state_nx = S_DONE;
                end else if (run_tc) begin
                    state_nx = S_ERR;
                end
            end
            S_DONE:   if (start) state_nx = S_IDLE;
            S_ERR:    if (start) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded directly from the registered state
    always_comb begin
        s_ready = (state == S_HDR) || (state == S_LOAD);
        state_o = state;
    end

    // Datapath: length/address counters, registered imem port, core reset, cycle counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_cnt   <= '0;
            addr_cnt  <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_data   <= '0;
            cpu_reset <= 1'b1;
            cycle_cnt <= '0;
        end else begin
            im_we     <= 1'b0;
            // Looking at next state lets the core leave reset on the first RUN cycle.
            cpu_reset <= (state_nx != S_RUN);

            if (state == S_IDLE && start) begin
                cycle_cnt <= '0;
            end

            if (state == S_HDR && xfer && !hdr_bad) begin
                len_cnt  <= s_data[AW-1:0];
                addr_cnt <= '0;
            end

            if (state == S_LOAD && xfer) begin
                im_we    <= 1'b1;
                im_addr  <= addr_cnt;
                im_data  <= s_data;
                addr_cnt <= addr_cnt + AW'(1);
                if (!last_word) begin
                    len_cnt <= len_cnt - AW'(1);
                end
            end

            if (state == S_RUN && !cpu_done) begin
                cycle_cnt <= cycle_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader.
// A transaction-level reference model predicts every output on every cycle.
// Directed scenarios add literal expectations at the key points.
module tb_prog_loader;

    localparam int MAXC = 16;
    localparam int M_IDLE = 0, M_HDR = 1, M_LOAD = 2, M_SETTLE = 3,
                   M_RUN = 4, M_DONE = 5, M_ERR = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [8:0] s_data = 9'h000;
    logic       cpu_done = 1'b0;
    logic       s_ready;
    logic       im_we;
    logic [7:0] im_addr;
    logic [8:0] im_data;
    logic       cpu_reset;
    logic [15:0] cycle_cnt;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    prog_loader #(.IW(9), .AW(8), .CW(16), .MAX_CYCLES(MAXC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .cpu_reset (cpu_reset),
        .cpu_done  (cpu_done),
        .cycle_cnt (cycle_cnt),
        .state_o   (state_o)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: phase, words outstanding, next write slot, run counter, expected imem port
    int m_st = M_IDLE, m_left = 0, m_ptr = 0, m_cnt = 0;
    int m_we = 0, m_addr = 0, m_data = 0;

    always @(posedge clk) begin : model
        bit take;
        take = s_valid && (m_st == M_HDR || m_st == M_LOAD);
        if (!reset) begin
            m_st = M_IDLE; m_left = 0; m_ptr = 0; m_cnt = 0;
            m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            m_we = 0;
            case (m_st)
                M_IDLE: if (start) begin m_st = M_HDR; m_cnt = 0; end
                M_HDR: if (take) begin
                    if (s_data[8]) m_st = M_ERR;
                    else begin
                        m_left = int'(s_data[7:0]) + 1;
                        m_ptr  = 0;
                        m_st   = M_LOAD;
                    end
                end
                M_LOAD: if (take) begin
                    m_we   = 1;
                    m_addr = m_ptr;
                    m_data = int'(s_data);
                    m_ptr  = (m_ptr + 1) % 256;
                    m_left = m_left - 1;
                    if (m_left == 0) m_st = M_SETTLE;
                end
                M_SETTLE: m_st = M_RUN;
                M_RUN: begin
                    if (cpu_done) m_st = M_DONE;
                    else begin
                        m_cnt = m_cnt + 1;
                        if (m_cnt == MAXC) m_st = M_ERR;
                    end
                end
                default: if (start) m_st = M_IDLE;
            endcase
        end
    end

    // Shadow imem and write log, used by the directed checks
    logic [8:0] mem [256];
    int wcount = 0, w0count = 0, cyc = 0;
    int we_cyc [1024];
    bit live = 0;

    // Compare every output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (live) begin
            chk("state_o",   int'(state_o),   m_st);
            chk("s_ready",   int'(s_ready),   int'(m_st == M_HDR || m_st == M_LOAD));
            chk("im_we",     int'(im_we),     m_we);
            chk("im_addr",   int'(im_addr),   m_addr);
            chk("im_data",   int'(im_data),   m_data);
            chk("cpu_reset", int'(cpu_reset), int'(m_st != M_RUN));
            chk("cycle_cnt", int'(cycle_cnt), m_cnt);
        end
        if (im_we === 1'b1) begin
            mem[im_addr] = im_data;
            if (wcount < 1024) we_cyc[wcount] = cyc;
            wcount++;
            if (im_addr == 8'h00) w0count++;
        end
        cyc++;
    end

    logic [8:0] prog [256];

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    // start, header, then n words (optionally with an idle cycle between words)
    task automatic do_load(input logic [8:0] hdr, input int n, input bit gap);
        pulse_start();
        chk("cnt_cleared_on_start", int'(cycle_cnt), 0);
        s_valid = 1'b1; s_data = hdr; tick();
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = prog[i]; tick();
            if (gap && i < n - 1) begin
                s_valid = 1'b0; s_data = 9'h0AA; tick();
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, z0, k;
        live = 1'b1;
        repeat (3) tick();
        chk("rst_state", int'(state_o), 0);
        chk("rst_cpu_reset", int'(cpu_reset), 1);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_im_we", int'(im_we), 0);
        chk("rst_cycle_cnt", int'(cycle_cnt), 0);
        reset = 1'b1;
        tick();

        // Back-to-back load of four words
        prog[0] = 9'h1A0; prog[1] = 9'h0C1; prog[2] = 9'h142; prog[3] = 9'h1FF;
        w0 = wcount;
        do_load(9'h003, 4, 1'b0);
        chk("b2b_settle_state", int'(state_o), 3);
        chk("b2b_settle_we", int'(im_we), 1);
        chk("b2b_settle_cpu_reset", int'(cpu_reset), 1);
        chk("b2b_writes", wcount - w0, 4);
        chk("b2b_consecutive", we_cyc[w0 + 3] - we_cyc[w0], 3);
        chk("b2b_mem0", int'(mem[0]), 'h1A0);
        chk("b2b_mem3", int'(mem[3]), 'h1FF);
        tick();
        chk("run_state", int'(state_o), 4);
        chk("run_cpu_reset", int'(cpu_reset), 0);

        // cpu_done on the 10th RUN cycle
        repeat (9) tick();
        cpu_done = 1'b1; tick(); cpu_done = 1'b0;
        chk("done_state", int'(state_o), 5);
        chk("done_cnt", int'(cycle_cnt), 9);
        chk("done_cpu_reset", int'(cpu_reset), 1);
        tick();
        chk("done_frozen", int'(cycle_cnt), 9);
        pulse_start();
        chk("done_to_idle", int'(state_o), 0);
        chk("idle_cnt_kept", int'(cycle_cnt), 9);

        // Load with s_valid toggling, then let it time out
        w0 = wcount;
        do_load(9'h003, 4, 1'b1);
        chk("gap_writes", wcount - w0, 4);
        chk("gap_spacing", we_cyc[w0 + 1] - we_cyc[w0], 2);
        chk("gap_mem2", int'(mem[2]), 'h142);
        k = 0;
        while (state_o != 3'd6 && k < 40) begin tick(); k++; end
        chk("timeout_reached", int'(k < 40), 1);
        chk("timeout_cnt", int'(cycle_cnt), 16);
        chk("timeout_cpu_reset", int'(cpu_reset), 1);
        pulse_start();

        // done arrives on the same edge as the timeout
        do_load(9'h003, 4, 1'b0);
        k = 0;
        while (cycle_cnt != 16'd15 && k < 40) begin tick(); k++; end
        chk("tc_edge_reached", int'(k < 40), 1);
        cpu_done = 1'b1; tick(); cpu_done = 1'b0;
        chk("tie_state", int'(state_o), 5);
        chk("tie_cnt", int'(cycle_cnt), 15);
        pulse_start();

        // Malformed header
        w0 = wcount;
        pulse_start();
        s_valid = 1'b1; s_data = 9'h100; tick(); s_valid = 1'b0;
        chk("badhdr_state", int'(state_o), 6);
        chk("badhdr_cpu_reset", int'(cpu_reset), 1);
        tick();
        chk("badhdr_hold", int'(state_o), 6);
        chk("badhdr_no_writes", wcount - w0, 0);
        pulse_start();

        // Full 256-word load, then reset mid-RUN
        for (int i = 0; i < 256; i++) prog[i] = 9'((i * 7 + 3) % 512);
        w0 = wcount; z0 = w0count;
        do_load(9'h0FF, 256, 1'b0);
        chk("full_writes", wcount - w0, 256);
        chk("full_last_addr", int'(im_addr), 255);
        chk("full_state", int'(state_o), 3);
        chk("full_addr0_once", w0count - z0, 1);
        chk("full_mem0", int'(mem[0]), 3);
        chk("full_mem255", int'(mem[255]), (255 * 7 + 3) % 512);
        repeat (4) tick();
        chk("midrun_state", int'(state_o), 4);
        reset = 1'b0; tick();
        chk("rstrun_state", int'(state_o), 0);
        chk("rstrun_im_we", int'(im_we), 0);
        chk("rstrun_cpu_reset", int'(cpu_reset), 1);
        chk("rstrun_cnt", int'(cycle_cnt), 0);
        chk("rstrun_s_ready", int'(s_ready), 0);
        reset = 1'b1; tick();

        // Reset while the 3rd LOAD word is offered
        w0 = wcount;
        pulse_start();
        s_valid = 1'b1; s_data = 9'h005; tick();
        s_data = prog[0]; tick();
        s_data = prog[1]; tick();
        s_data = prog[2]; reset = 1'b0; tick();
        s_valid = 1'b0;
        chk("rstload_state", int'(state_o), 0);
        chk("rstload_im_we", int'(im_we), 0);
        chk("rstload_cpu_reset", int'(cpu_reset), 1);
        chk("rstload_cnt", int'(cycle_cnt), 0);
        chk("rstload_s_ready", int'(s_ready), 0);
        chk("rstload_writes", wcount - w0, 2);
        reset = 1'b1; tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time stage directly upstream of the CPU core. It owns the instruction-memory write port and the core's reset line.
- Accepts a valid/ready stream of 9-bit instruction words (a header word followed by N program words) and writes them to imem addresses 0..N-1.
- After loading, it releases the core from reset, counts execution cycles until the core raises done, then holds the core in reset and reports the result.
- A timeout terminates runaway programs.

Parameters:
- IW, 9, instruction word width (matches the core's machine-code width)
- AW, 8, imem address width (matches the PC width)
- CW, 16, cycle-counter width
- MAX_CYCLES, 4096, RUN cycles allowed before timeout; must be 2..2^CW-1

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- start  in  1  begins a load from IDLE; from DONE/ERR, returns to IDLE
- s_valid  in  1  stream word valid
- s_data  in  IW  stream word
- s_ready  out  1  stream ready
- im_we  out  1  imem write enable (registered)
- im_addr  out  AW  imem write address (registered)
- im_data  out  IW  imem write data (registered)
- cpu_reset  out  1  core reset, active-high (registered)
- cpu_done  in  1  core done flag
- cycle_cnt  out  CW  RUN cycles counted
- state_o  out  3  IDLE=0, HDR=1, LOAD=2, SETTLE=3, RUN=4, DONE=5, ERR=6

Behaviour:
- Reset (reset==0 at a clk edge), from any state including mid-LOAD and mid-RUN:
  - state IDLE, s_ready=0, im_we=0, im_addr=0, im_data=0, cpu_reset=1, cycle_cnt=0, internal length and address counters 0.
  - A partial load is abandoned; imem contents are not cleared.
- Transfer rule: a word transfers on a clk edge with s_valid&&s_ready. s_ready is registered-state decoded: 1 only in HDR and LOAD. s_data is ignored when no transfer occurs.
- IDLE:
  - cpu_reset=1.
  - start=1 -> HDR, with cycle_cnt cleared to 0.
- HDR:
  - The first transferred word is the header.
  - s_data[8]==1 -> ERR (malformed header).
  - Otherwise len = s_data[7:0] + 1 (1..256 words), addr counter = 0, -> LOAD.
- LOAD:
  - Each transfer writes the word with 1-cycle latency: on the next edge im_we=1, im_addr=addr counter, im_data=word. The addr counter then increments (AW bits, wraps only after the 256th word).
  - The transfer of word number len -> SETTLE.
  - Back-to-back transfers every cycle are supported.
  - No transfer -> im_we=0 the next cycle, holding im_addr/im_data.
- SETTLE:
  - Exactly 1 cycle. The final imem write (im_we=1) is visible during this cycle; cpu_reset stays 1.
  - -> RUN.
- RUN:
  - cpu_reset=0 from the first RUN cycle.
  - Each RUN cycle with cpu_done=0: cycle_cnt++.
  - cpu_done=1 -> DONE, cycle_cnt unchanged that cycle.
  - cycle_cnt reaching MAX_CYCLES while cpu_done=0 -> ERR.
  - cpu_done=1 on the same edge as the timeout: done wins.
- DONE / ERR:
  - cpu_reset=1, cycle_cnt frozen, s_ready=0, im_we=0.
  - start=1 -> IDLE.
- start is ignored in HDR, LOAD, SETTLE and RUN.
- cpu_done is ignored outside RUN.
- im_we is never 1 outside the cycle after a LOAD transfer.
- cpu_reset is never 0 outside RUN.

Test Plan:
- Reset, start, header 0x003, then 4 words 0x1A0,0x0C1,0x142,0x1FF with s_valid held high -> im_we pulses 4 consecutive cycles at addr 0..3 with matching data; SETTLE 1 cycle; cpu_reset falls on the next cycle.
- Same load with s_valid toggled 1,0,1,0 -> s_ready high throughout LOAD; im_we pulses only the cycle after each transfer; addresses 0..3 without gaps; no duplicate writes.
- RUN with cpu_done raised on the 10th RUN cycle -> state DONE, cycle_cnt=9, cpu_reset=1; a start pulse returns to IDLE with cycle_cnt still 9; the next start clears it to 0.
- Header 0x100 (bit 8 set) -> ERR the following cycle; no im_we pulses; cpu_reset stays 1. Header 0x0FF -> 256 words loaded, final im_addr=0xFF, no wrap write to 0.
- cpu_done held 0 with MAX_CYCLES=16 -> ERR when cycle_cnt=16. Repeat with cpu_done=1 on that same edge -> DONE with cycle_cnt=15.
- reset driven low on the 3rd LOAD word and separately mid-RUN -> next cycle state IDLE, im_we=0, cpu_reset=1, cycle_cnt=0, s_ready=0.
